timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
Parametrised bank of NUM_TIMERS programmable interval timers with a byte-wide CPU register window at 0x93xx. It adds a shared prescaler, one-shot and periodic modes, per-channel IRQ enable, write-1-to-clear status and tear-free multi-byte value reads. It drives the CPU irq_n line and exposes a per-channel pending vector for the system status byte.

Parameters:
NUM_TIMERS, 8, number of channels (1..8)
TICK_WIDTH, 20, counter/limit width in bits (1..24)
PRESCALE_WIDTH, 8, prescaler register/counter width (1..8)

Ports:
sys_clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
cs  in  1  register window select (address decode done outside)
addr  in  4  register offset
wr_en  in  1  write strobe, one sys_clk, qualified by cs
wr_data  in  8  write data
rd_strobe  in  1  single-cycle read-request rising edge, qualified by cs
rd_data  out  8  registered read data
irq_pending  out  NUM_TIMERS  per-channel pending flags, bit i = timer i
irq_n  out  1  active-low OR of (pending & irq_en) over all channels

Behaviour:
- Registers (offset: W / R):
  - 0: INDEX W/R, bits[2:0] select channel; an index >= NUM_TIMERS selects nothing, reads 0.
  - 1,2,3: LIMIT byte 0/1/2 W into a staging register; R returns the value snapshot bytes 0/1/2.
  - 4: CTRL W/R for the selected channel: bit0 enable, bit1 periodic (0 = one-shot), bit2 irq_en.
  - 5: COMMIT W (any data): staging goes to the selected channel's limit; the channel value is cleared to 0. R returns 0.
  - 6: STATUS R = irq_pending zero-extended; W writes 1 to clear bit i.
  - 7: PRESCALE W/R.
  - 8-15: R returns 0, writes ignored.
- Limit bits above TICK_WIDTH are dropped. Reading snapshot bits above TICK_WIDTH returns 0.
- Read timing:
  - rd_data is registered and valid the cycle after cs with addr stable.
  - It updates every cycle cs is high and holds otherwise.
- Snapshot:
  - rd_strobe with addr==1 captures the full value of the selected channel into the snapshot in that cycle; rd_data for addr 1 shows the captured low byte.
  - Reads of addr 2/3 never recapture.
- Prescaler:
  - Free-running counter. When counter == PRESCALE, a one-cycle tick is emitted and the counter returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE clears the counter in the same cycle.
- Channel behaviour, on tick while enabled:
  - If value == limit: pending <= 1 and value <= 0. One-shot also clears enable. Periodic continues.
  - Otherwise value <= value+1.
  - limit=0 fires on every tick.
  - A disabled channel holds its value.
- Simultaneous events:
  - Expiry and a STATUS clear of the same bit in one cycle: pending stays 1 (set wins).
  - COMMIT and expiry in one cycle: COMMIT wins, no pending is set.
  - CTRL write and expiry in one cycle: the CTRL write wins over the one-shot auto-disable.
- irq_n is combinational from the registered pending and irq_en flags. Pending sets regardless of irq_en.
- Reset: all limits, values, staging, CTRL bits, pending, INDEX, PRESCALE, prescaler counter, snapshot and rd_data go to 0; irq_n=1.
  - Reset mid-count abandons the count with no IRQ.
  - Reset has priority over all writes.

Decomposition:
- Include file timer_bank.vh: register offset localparams (TB_INDEX..TB_PRESCALE) and CTRL bit positions, shared with firmware headers.
- Sub-module timer_channel (generate-instantiated NUM_TIMERS times).
  - Inputs: tick, commit, limit_in, ctrl_wr, ctrl_in, clear.
  - Outputs: value, ctrl, pending.
- The prescaler and register decode stay in timer_bank.

Test Plan:
1. PRESCALE=0, ch0 limit=3, CTRL=0b111 -> pending[0] rises on the 4th tick after enable; irq_n low; the flag repeats every 4 cycles while uncleared.
2. ch2 one-shot limit=5, PRESCALE=9 -> pending[2] asserts 60 cycles after enable; ch2 enable reads 0; value stays 0.
3. Count ch1 with limit=0xFFFFF; rd_strobe at addr 1 when value=0x0A0FF, then read addr 2/3 later -> returns 0xFF, 0xA0, 0x00 despite counting.
4. Write STATUS=0x01 in the exact cycle ch0 expires -> pending[0] remains 1; a subsequent clear drops it and irq_n returns high.
5. CTRL irq_en=0 on ch3 with expiry -> pending[3]=1, STATUS bit3 = 1, irq_n stays 1.
6. Assert reset_n=0 for one cycle mid-count with pending set -> every register reads 0 the cycle after reset release and irq_n=1.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared register map and channel control type for the timer bank.
package timer_bank_pkg;

   `include "timer_bank.vh"

   // Packed so that bit positions match the CTRL register layout.
   typedef struct packed {
      logic irq_en;
      logic periodic;
      logic enable;
   } timer_ctrl_t;

   localparam int SNAP_WIDTH = 24;

endpackage

// File: rtl/timer_bank.vh
// Register offsets and CTRL bit positions for the timer bank window at 0x93xx.
// Kept as a plain include so firmware headers can mirror the same values.
`ifndef TIMER_BANK_VH
`define TIMER_BANK_VH

localparam logic [3:0] TB_INDEX    = 4'd0;
localparam logic [3:0] TB_LIMIT0   = 4'd1;
localparam logic [3:0] TB_LIMIT1   = 4'd2;
localparam logic [3:0] TB_LIMIT2   = 4'd3;
localparam logic [3:0] TB_CTRL     = 4'd4;
localparam logic [3:0] TB_COMMIT   = 4'd5;
localparam logic [3:0] TB_STATUS   = 4'd6;
localparam logic [3:0] TB_PRESCALE = 4'd7;

localparam int TB_CTRL_ENABLE   = 0;
localparam int TB_CTRL_PERIODIC = 1;
localparam int TB_CTRL_IRQ_EN   = 2;

`endif

// File: rtl/timer_channel.sv
// One interval timer: counts on prescaler ticks, flags pending when value reaches limit.
module timer_channel
   import timer_bank_pkg::*;
#(
   parameter int TICK_WIDTH = 20
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   input  logic                  tick,
   input  logic                  commit,
   input  logic [TICK_WIDTH-1:0] limit_in,
   input  logic                  ctrl_wr,
   input  timer_ctrl_t           ctrl_in,
   input  logic                  clear,
   output logic [TICK_WIDTH-1:0] value,
   output timer_ctrl_t           ctrl,
   output logic                  pending
);

   logic [TICK_WIDTH-1:0] limit;
   logic                  at_limit;
   logic                  fire;

   // A commit in the same cycle cancels the expiry entirely.
   assign at_limit = (value == limit);
   assign fire     = tick & ctrl.enable & at_limit & ~commit;

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         limit <= '0;
         value <= '0;
      end else if (commit) begin
         limit <= limit_in;
         value <= '0;
      end else if (tick && ctrl.enable) begin
         value <= at_limit ? '0 : value + TICK_WIDTH'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         ctrl <= '0;
      end else if (ctrl_wr) begin
         ctrl <= ctrl_in;
      end else if (fire && !ctrl.periodic) begin
         ctrl.enable <= 1'b0;
      end
   end

   // Set beats a simultaneous write-1-to-clear.
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         pending <= 1'b0;
      end else if (fire) begin
         pending <= 1'b1;
      end else if (clear) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/timer_bank.sv
// Bank of programmable interval timers behind a byte-wide register window,
// with a shared prescaler, tear-free value snapshots and an active-low IRQ.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int NUM_TIMERS     = 8,
   parameter int TICK_WIDTH     = 20,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   input  logic                  cs,
   input  logic [3:0]            addr,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   input  logic                  rd_strobe,
   output logic [7:0]            rd_data,
   output logic [NUM_TIMERS-1:0] irq_pending,
   output logic                  irq_n
);

   logic [2:0]                index;
   logic [TICK_WIDTH-1:0]     staging;
   logic [SNAP_WIDTH-1:0]     snapshot;
   logic [SNAP_WIDTH-1:0]     sel_value;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [PRESCALE_WIDTH-1:0] prescale_cnt;
   logic                      tick;
   logic                      wr;
   logic                      capture;
   logic [TICK_WIDTH-1:0]     chan_value [NUM_TIMERS];
   timer_ctrl_t               chan_ctrl  [NUM_TIMERS];
   timer_ctrl_t               sel_ctrl;
   timer_ctrl_t               ctrl_wdata;
   logic [NUM_TIMERS-1:0]     irq_active;
   logic [7:0]                rd_next;

   assign wr         = cs & wr_en;
   assign capture    = cs & rd_strobe & (addr == TB_LIMIT0);
   assign tick       = (prescale_cnt == prescale);
   assign ctrl_wdata = '{irq_en:   wr_data[TB_CTRL_IRQ_EN],
                         periodic: wr_data[TB_CTRL_PERIODIC],
                         enable:   wr_data[TB_CTRL_ENABLE]};

   for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
      logic sel;
      assign sel = (index == 3'(i));

      timer_channel #(
         .TICK_WIDTH(TICK_WIDTH)
      ) u_chan (
         .sys_clk  (sys_clk),
         .reset_n  (reset_n),
         .tick     (tick),
         .commit   (wr && (addr == TB_COMMIT) && sel),
         .limit_in (staging),
         .ctrl_wr  (wr && (addr == TB_CTRL) && sel),
         .ctrl_in  (ctrl_wdata),
         .clear    (wr && (addr == TB_STATUS) && wr_data[i]),
         .value    (chan_value[i]),
         .ctrl     (chan_ctrl[i]),
         .pending  (irq_pending[i])
      );

      assign irq_active[i] = irq_pending[i] & chan_ctrl[i].irq_en;
   end

   assign irq_n = ~|irq_active;

   // An out-of-range INDEX matches no channel, so it reads as zero.
   always_comb begin
      sel_value = '0;
      sel_ctrl  = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         if (index == 3'(i)) begin
            sel_value = SNAP_WIDTH'(chan_value[i]);
            sel_ctrl  = chan_ctrl[i];
         end
      end
   end

   // The capturing read of the low byte shows the freshly captured value.
   always_comb begin
      rd_next = '0;
      case (addr)
         TB_INDEX:    rd_next = {5'b0, index};
         TB_LIMIT0:   rd_next = capture ? sel_value[7:0] : snapshot[7:0];
         TB_LIMIT1:   rd_next = snapshot[15:8];
         TB_LIMIT2:   rd_next = snapshot[23:16];
         TB_CTRL:     rd_next = {5'b0, sel_ctrl};
         TB_STATUS:   rd_next[NUM_TIMERS-1:0] = irq_pending;
         TB_PRESCALE: rd_next[PRESCALE_WIDTH-1:0] = prescale;
         default:     rd_next = '0;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         index        <= '0;
         staging      <= '0;
         prescale     <= '0;
         prescale_cnt <= '0;
         snapshot     <= '0;
         rd_data      <= '0;
      end else begin
         if (wr && (addr == TB_INDEX)) begin
            index <= wr_data[2:0];
         end
         if (wr && (addr == TB_PRESCALE)) begin
            prescale <= wr_data[PRESCALE_WIDTH-1:0];
         end
         // Limit bytes land bit by bit so anything above TICK_WIDTH is dropped.
         for (int b = 0; b < TICK_WIDTH; b++) begin
            if (wr && (addr == 4'(TB_LIMIT0 + b / 8))) begin
               staging[b] <= wr_data[b % 8];
            end
         end
         if ((wr && (addr == TB_PRESCALE)) || tick) begin
            prescale_cnt <= '0;
         end else begin
            prescale_cnt <= prescale_cnt + PRESCALE_WIDTH'(1);
         end
         if (capture) begin
            snapshot <= sel_value;
         end
         if (cs) begin
            rd_data <= rd_next;
         end
      end
   end

endmodule

// File: tb/tb_timer_bank.sv
// Randomised and directed checks of timer_bank against a cycle-level behavioural model.
module tb_timer_bank;
   import timer_bank_pkg::*;

   localparam int NT    = 8;
   localparam int TMASK = (1 << 20) - 1;

   logic          sys_clk = 1'b0;
   logic          reset_n;
   logic          cs;
   logic [3:0]    addr;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          rd_strobe;
   logic [7:0]    rd_data;
   logic [NT-1:0] irq_pending;
   logic          irq_n;

   int testsRun    = 0;
   int testsFailed = 0;

   int          m_value [NT];
   int          m_limit [NT];
   bit          m_en    [NT];
   bit          m_per   [NT];
   bit          m_irq   [NT];
   bit          m_pend  [NT];
   logic [23:0] m_stage;
   int          m_index;
   int          m_prescale;
   int          m_pcnt;
   int          m_snap;
   logic [7:0]  m_rd;

   always #5 sys_clk = ~sys_clk;

   timer_bank #(
      .NUM_TIMERS     (NT),
      .TICK_WIDTH     (20),
      .PRESCALE_WIDTH (8)
   ) dut (
      .sys_clk     (sys_clk),
      .reset_n     (reset_n),
      .cs          (cs),
      .addr        (addr),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_strobe   (rd_strobe),
      .rd_data     (rd_data),
      .irq_pending (irq_pending),
      .irq_n       (irq_n)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [NT-1:0] pend_vec();
      logic [NT-1:0] v;
      v = '0;
      for (int i = 0; i < NT; i++) v[i] = m_pend[i];
      return v;
   endfunction

   function automatic logic exp_irq_n();
      for (int i = 0; i < NT; i++) if (m_pend[i] && m_irq[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NT; i++) begin
         m_value[i] = 0; m_limit[i] = 0;
         m_en[i] = 0; m_per[i] = 0; m_irq[i] = 0; m_pend[i] = 0;
      end
      m_stage = '0; m_index = 0; m_prescale = 0; m_pcnt = 0; m_snap = 0; m_rd = '0;
   endtask

   // Advances the reference model by one clock using the inputs currently driven.
   task automatic modelStep();
      bit tick, wr, commit, ctrlw, clr, fire;
      int a;
      if (!reset_n) begin
         modelReset();
         return;
      end
      a    = int'(addr);
      tick = (m_pcnt == m_prescale);
      wr   = cs && wr_en;
      if (cs && rd_strobe && a == 1) m_snap = (m_index < NT) ? m_value[m_index] : 0;
      if (cs) begin
         case (a)
            0:       m_rd = 8'(m_index);
            1:       m_rd = 8'(m_snap);
            2:       m_rd = 8'(m_snap >> 8);
            3:       m_rd = 8'(m_snap >> 16);
            4:       m_rd = (m_index < NT) ? {5'b0, m_irq[m_index], m_per[m_index], m_en[m_index]} : 8'h00;
            6:       m_rd = 8'(pend_vec());
            7:       m_rd = 8'(m_prescale);
            default: m_rd = 8'h00;
         endcase
      end
      for (int i = 0; i < NT; i++) begin
         commit = wr && a == 5 && m_index == i;
         ctrlw  = wr && a == 4 && m_index == i;
         clr    = wr && a == 6 && wr_data[i];
         fire   = tick && m_en[i] && m_value[i] == m_limit[i] && !commit;
         if (commit) begin
            m_limit[i] = int'(m_stage);
            m_value[i] = 0;
         end else if (tick && m_en[i]) begin
            m_value[i] = fire ? 0 : m_value[i] + 1;
         end
         if (ctrlw) begin
            m_en[i] = wr_data[0]; m_per[i] = wr_data[1]; m_irq[i] = wr_data[2];
         end else if (fire && !m_per[i]) begin
            m_en[i] = 0;
         end
         if (fire) m_pend[i] = 1;
         else if (clr) m_pend[i] = 0;
      end
      if (wr && a == 0) m_index = int'(wr_data) % 8;
      if (wr && a == 1) m_stage[7:0]   = wr_data;
      if (wr && a == 2) m_stage[15:8]  = wr_data;
      if (wr && a == 3) m_stage[23:16] = wr_data;
      m_stage = m_stage & 24'(TMASK);
      if (wr && a == 7) begin
         m_prescale = int'(wr_data);
         m_pcnt     = 0;
      end else begin
         m_pcnt = tick ? 0 : (m_pcnt + 1) % 256;
      end
   endtask

   task automatic applyStimulus(input bit c, input int a, input bit w, input int d, input bit s);
      cs = c; addr = 4'(a); wr_en = w; wr_data = 8'(d); rd_strobe = s;
      modelStep();
      @(posedge sys_clk);
      #1;
      checkOutput("rd_data", 32'(rd_data), 32'(m_rd));
      checkOutput("irq_pending", 32'(irq_pending), 32'(pend_vec()));
      checkOutput("irq_n", 32'(irq_n), 32'(exp_irq_n()));
   endtask

   task automatic writeReg(input int a, input int d);
      applyStimulus(1'b1, a, 1'b1, d, 1'b0);
   endtask

   task automatic readReg(input int a, input bit s);
      applyStimulus(1'b1, a, 1'b0, 0, s);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   // A write is driven alongside reset to confirm reset wins.
   task automatic resetCycle(input int a, input int d);
      reset_n = 1'b0; cs = 1'b1; addr = 4'(a); wr_en = 1'b1; wr_data = 8'(d); rd_strobe = 1'b1;
      modelStep();
      @(posedge sys_clk);
      #1;
      checkOutput("reset_rd_data", 32'(rd_data), 32'h0);
      checkOutput("reset_pending", 32'(irq_pending), 32'h0);
      checkOutput("reset_irq_n", 32'(irq_n), 32'h1);
      reset_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cycles, r, a, d;
      reset_n = 1'b0; cs = 1'b0; addr = '0; wr_en = 1'b0; wr_data = '0; rd_strobe = 1'b0;
      modelReset();
      @(posedge sys_clk);
      #1;
      resetCycle(7, 3);
      for (int k = 0; k < 16; k++) begin
         readReg(k, 1'b0);
         checkOutput("reset_reg", 32'(rd_data), 32'h0);
      end

      // One-shot channel 2, limit 5, prescale 9
      writeReg(TB_INDEX, 2); writeReg(TB_LIMIT0, 5); writeReg(TB_LIMIT1, 0); writeReg(TB_LIMIT2, 0);
      writeReg(TB_COMMIT, 0); writeReg(TB_PRESCALE, 9); writeReg(TB_CTRL, 5);
      cycles = 1;
      while (!irq_pending[2] && cycles < 200) begin idleCycle(); cycles++; end
      checkOutput("oneshot_latency", 32'(cycles), 32'd60);
      checkOutput("oneshot_irq_n", 32'(irq_n), 32'h0);
      readReg(TB_CTRL, 1'b0);
      checkOutput("oneshot_ctrl", 32'(rd_data), 32'h04);
      readReg(TB_LIMIT0, 1'b1);
      checkOutput("oneshot_value", 32'(rd_data), 32'h00);
      writeReg(TB_STATUS, 8'h04); writeReg(TB_PRESCALE, 0); writeReg(TB_CTRL, 0);

      // Periodic channel 0, limit 3, every-cycle tick
      writeReg(TB_INDEX, 0); writeReg(TB_LIMIT0, 3); writeReg(TB_COMMIT, 0); writeReg(TB_CTRL, 7);
      cycles = 0;
      while (!irq_pending[0] && cycles < 50) begin idleCycle(); cycles++; end
      checkOutput("periodic_first", 32'(cycles), 32'd4);
      checkOutput("periodic_irq_n", 32'(irq_n), 32'h0);
      writeReg(TB_STATUS, 8'h01);
      cycles = 1;
      while (!irq_pending[0] && cycles < 50) begin idleCycle(); cycles++; end
      checkOutput("periodic_repeat", 32'(cycles), 32'd4);

      // STATUS clear landing on the expiry cycle
      cycles = 0;
      while (m_value[0] != m_limit[0] && cycles < 20) begin idleCycle(); cycles++; end
      writeReg(TB_STATUS, 8'h01);
      checkOutput("clear_vs_expiry", 32'(irq_pending[0]), 32'h1);
      writeReg(TB_STATUS, 8'h01);
      checkOutput("clear_after", 32'(irq_pending[0]), 32'h0);
      checkOutput("clear_irq_n", 32'(irq_n), 32'h1);
      writeReg(TB_CTRL, 0);

      // Channel 3 expiring with irq_en off
      writeReg(TB_INDEX, 3); writeReg(TB_LIMIT0, 2); writeReg(TB_COMMIT, 0); writeReg(TB_CTRL, 3);
      cycles = 0;
      while (!irq_pending[3] && cycles < 20) begin idleCycle(); cycles++; end
      checkOutput("noirq_pending", 32'(irq_pending[3]), 32'h1);
      readReg(TB_STATUS, 1'b0);
      checkOutput("noirq_status", 32'(rd_data[3]), 32'h1);
      checkOutput("noirq_irq_n", 32'(irq_n), 32'h1);
      writeReg(TB_CTRL, 0); writeReg(TB_STATUS, 8'h08);

      // Tear-free snapshot of a wide count on channel 1
      writeReg(TB_INDEX, 1); writeReg(TB_LIMIT0, 8'hFF); writeReg(TB_LIMIT1, 8'hFF); writeReg(TB_LIMIT2, 8'hFF);
      writeReg(TB_COMMIT, 0); writeReg(TB_CTRL, 3);
      cycles = 0;
      while (m_value[1] != 'h0A0FF && cycles < 50000) begin idleCycle(); cycles++; end
      readReg(TB_LIMIT0, 1'b1);
      checkOutput("snap_byte0", 32'(rd_data), 32'hFF);
      for (int k = 0; k < 5; k++) idleCycle();
      readReg(TB_LIMIT1, 1'b0);
      checkOutput("snap_byte1", 32'(rd_data), 32'hA0);
      readReg(TB_LIMIT2, 1'b0);
      checkOutput("snap_byte2", 32'(rd_data), 32'h00);

      // Random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 99);
         a = $urandom_range(0, 15);
         d = $urandom_range(0, 255);
         if (r < 30) begin
            applyStimulus(1'($urandom_range(0, 1)), a, 1'b0, d, 1'b0);
         end else if (r < 65) begin
            if (a == 7) d = $urandom_range(0, 3);
            else if (a == 1) d = $urandom_range(0, 12);
            else if ((a == 2 || a == 3) && $urandom_range(0, 9) != 0) d = 0;
            applyStimulus($urandom_range(0, 3) != 0, a, 1'b1, d, 1'b0);
         end else if (r < 99) begin
            applyStimulus($urandom_range(0, 3) != 0, a, 1'b0, d, 1'($urandom_range(0, 1)));
         end else begin
            resetCycle(a, d);
         end
      end

      // Reset mid-count with a pending flag raised
      writeReg(TB_PRESCALE, 0); writeReg(TB_INDEX, 0); writeReg(TB_LIMIT0, 2); writeReg(TB_LIMIT1, 0);
      writeReg(TB_LIMIT2, 0); writeReg(TB_COMMIT, 0); writeReg(TB_CTRL, 7);
      for (int k = 0; k < 5; k++) idleCycle();
      checkOutput("pre_reset_pending", 32'(irq_pending[0]), 32'h1);
      resetCycle(TB_CTRL, 7);
      for (int k = 0; k < 16; k++) begin
         readReg(k, k == 1);
         checkOutput("post_reset_reg", 32'(rd_data), 32'h0);
         checkOutput("post_reset_irq_n", 32'(irq_n), 32'h1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
